// File: rtl/biu_constants_pkg.sv
// Shared BIU transfer attribute types, arbiter state encoding and the
// burst-length decode used by the instruction/data BIU arbiter.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_DATA       = 3'b001;
  localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
  localparam biu_prot_t PROT_CACHEABLE  = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } biu_arb_state_t;

  localparam int BEAT_CNT_W = 5;

  // Undefined-length INCR is treated as a single beat.
  function automatic logic [BEAT_CNT_W-1:0] biu_type2beats(input biu_type_t t);
    case (t)
      WRAP4, INCR4:   biu_type2beats = 5'd4;
      WRAP8, INCR8:   biu_type2beats = 5'd8;
      WRAP16, INCR16: biu_type2beats = 5'd16;
      default:        biu_type2beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_biu_arb_if.sv
// Shared BIU bus bundle: the master side issues requests, the slave side
// returns strobe acknowledge, beat acknowledges, read data and tags.
interface riscv_biu_arb_if
  import biu_constants_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = (XLEN == 32) ? 34 : 56,
  parameter int BIUTAG_SIZE = 1
);
  logic                   stb;
  logic [PLEN-1:0]        adri;
  biu_size_t              size;
  biu_type_t              typ;
  logic                   we;
  logic                   lock;
  biu_prot_t              prot;
  logic [XLEN-1:0]        d;
  logic [BIUTAG_SIZE-1:0] tagi;
  logic                   stb_ack;
  logic                   d_ack;
  logic                   ack;
  logic                   err;
  logic [PLEN-1:0]        adro;
  logic [XLEN-1:0]        q;
  logic [BIUTAG_SIZE-1:0] tago;

  modport master (
    output stb, adri, size, typ, we, lock, prot, d, tagi,
    input  stb_ack, d_ack, ack, err, adro, q, tago
  );

  modport slave (
    input  stb, adri, size, typ, we, lock, prot, d, tagi,
    output stb_ack, d_ack, ack, err, adro, q, tago
  );

endinterface

// File: rtl/riscv_biu_arb.sv
// Arbitrates the instruction and data memory controllers onto one BIU:
// round-robin on ties, lock-sticky ownership, owner held for a whole burst.
//
// Handshake: a requester holds stb_i until it sees stb_ack_o; the BIU takes a
// request when biu_stb_o and biu_stb_ack_i are both high in IDLE, then returns
// one biu_ack_i per beat (biu_err_i ends the burst early) while we are BUSY.
module riscv_biu_arb
  import biu_constants_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = (XLEN == 32) ? 34 : 56,
  parameter int BIUTAG_SIZE = 1
)(
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   im_stb_i,
  output logic                   im_stb_ack_o,
  output logic                   im_d_ack_o,
  output logic                   im_ack_o,
  output logic                   im_err_o,
  input  logic [PLEN-1:0]        im_adri_i,
  output logic [PLEN-1:0]        im_adro_o,
  input  biu_size_t              im_size_i,
  input  biu_type_t              im_type_i,
  input  biu_prot_t              im_prot_i,
  input  logic                   im_we_i,
  input  logic                   im_lock_i,
  input  logic [XLEN-1:0]        im_d_i,
  output logic [XLEN-1:0]        im_q_o,
  input  logic [BIUTAG_SIZE-1:0] im_tagi_i,
  output logic [BIUTAG_SIZE-1:0] im_tago_o,

  input  logic                   dm_stb_i,
  output logic                   dm_stb_ack_o,
  output logic                   dm_d_ack_o,
  output logic                   dm_ack_o,
  output logic                   dm_err_o,
  input  logic [PLEN-1:0]        dm_adri_i,
  output logic [PLEN-1:0]        dm_adro_o,
  input  biu_size_t              dm_size_i,
  input  biu_type_t              dm_type_i,
  input  biu_prot_t              dm_prot_i,
  input  logic                   dm_we_i,
  input  logic                   dm_lock_i,
  input  logic [XLEN-1:0]        dm_d_i,
  output logic [XLEN-1:0]        dm_q_o,
  input  logic [BIUTAG_SIZE-1:0] dm_tagi_i,
  output logic [BIUTAG_SIZE-1:0] dm_tago_o,

  output logic                   biu_stb_o,
  output logic [PLEN-1:0]        biu_adri_o,
  output biu_size_t              biu_size_o,
  output biu_type_t              biu_type_o,
  output logic                   biu_we_o,
  output logic                   biu_lock_o,
  output biu_prot_t              biu_prot_o,
  output logic [XLEN-1:0]        biu_d_o,
  output logic [BIUTAG_SIZE-1:0] biu_tagi_o,
  input  logic                   biu_stb_ack_i,
  input  logic                   biu_d_ack_i,
  input  logic                   biu_ack_i,
  input  logic                   biu_err_i,
  input  logic [PLEN-1:0]        biu_adro_i,
  input  logic [XLEN-1:0]        biu_q_i,
  input  logic [BIUTAG_SIZE-1:0] biu_tago_i,

  output biu_arb_state_t         state_o
);

  biu_arb_state_t        state, state_nxt;
  logic [BEAT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  rr_last, rr_last_nxt;   // 1: data was served last
  logic                  lock_act, lock_act_nxt; // last owner took the bus locked
  logic                  sel_d;
  logic                  locked;
  logic                  in_idle;
  logic                  gnt_stb;
  logic                  fwd_stb_ack, fwd_d_ack, fwd_ack, fwd_err;

  assign in_idle = (state == IDLE);
  assign locked  = lock_act & (rr_last ? dm_lock_i : im_lock_i);
  assign state_o = state;

  always_comb begin
    sel_d = 1'b0;
    case (state)
      BUSY_D: sel_d = 1'b1;
      BUSY_I: sel_d = 1'b0;
      default: begin
        if (locked)                      sel_d = rr_last;
        else if (im_stb_i && dm_stb_i)   sel_d = ~rr_last;
        else                             sel_d = dm_stb_i;
      end
    endcase
  end

  assign gnt_stb    = sel_d ? dm_stb_i  : im_stb_i;
  assign biu_stb_o  = rst_ni & in_idle & gnt_stb;
  assign biu_adri_o = sel_d ? dm_adri_i : im_adri_i;
  assign biu_size_o = sel_d ? dm_size_i : im_size_i;
  assign biu_type_o = sel_d ? dm_type_i : im_type_i;
  assign biu_we_o   = sel_d ? dm_we_i   : im_we_i;
  assign biu_lock_o = sel_d ? dm_lock_i : im_lock_i;
  assign biu_prot_o = sel_d ? dm_prot_i : im_prot_i;
  assign biu_d_o    = sel_d ? dm_d_i    : im_d_i;
  assign biu_tagi_o = sel_d ? dm_tagi_i : im_tagi_i;

  // Beat responses only pass while a burst is owned, so stray BIU acks in
  // IDLE (including right after reset) never reach a requester.
  assign fwd_stb_ack = biu_stb_o & biu_stb_ack_i;
  assign fwd_d_ack   = rst_ni & ~in_idle & biu_d_ack_i;
  assign fwd_ack     = rst_ni & ~in_idle & biu_ack_i;
  assign fwd_err     = rst_ni & ~in_idle & biu_err_i;

  assign im_stb_ack_o = ~sel_d & fwd_stb_ack;
  assign im_d_ack_o   = ~sel_d & fwd_d_ack;
  assign im_ack_o     = ~sel_d & fwd_ack;
  assign im_err_o     = ~sel_d & fwd_err;
  assign im_adro_o    = sel_d ? '0 : biu_adro_i;
  assign im_tago_o    = sel_d ? '0 : biu_tago_i;
  assign im_q_o       = biu_q_i;

  assign dm_stb_ack_o = sel_d & fwd_stb_ack;
  assign dm_d_ack_o   = sel_d & fwd_d_ack;
  assign dm_ack_o     = sel_d & fwd_ack;
  assign dm_err_o     = sel_d & fwd_err;
  assign dm_adro_o    = sel_d ? biu_adro_i : '0;
  assign dm_tago_o    = sel_d ? biu_tago_i : '0;
  assign dm_q_o       = biu_q_i;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rr_last_nxt  = rr_last;
    lock_act_nxt = lock_act;
    case (state)
      IDLE: begin
        if (biu_stb_o && biu_stb_ack_i) begin
          state_nxt    = sel_d ? BUSY_D : BUSY_I;
          cnt_nxt      = biu_type2beats(biu_type_o);
          rr_last_nxt  = sel_d;
          lock_act_nxt = biu_lock_o;
        end
      end
      BUSY_I, BUSY_D: begin
        if (biu_err_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (biu_ack_i) begin
          if (cnt <= 5'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 5'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_last  <= 1'b1;
      lock_act <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr_last  <= rr_last_nxt;
      lock_act <= lock_act_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_biu_arb.sv
// Bench for riscv_biu_arb: a simple BIU responder, a grant scoreboard fed by
// the scenario tasks, and per-scenario inline response/state checks.
module tb_riscv_biu_arb;
  import biu_constants_pkg::*;

  localparam int XLEN = 32;
  localparam int PLEN = 34;
  localparam int TW   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic im_stb_i, im_we_i, im_lock_i;
  logic [PLEN-1:0] im_adri_i;
  biu_size_t im_size_i;
  biu_type_t im_type_i;
  biu_prot_t im_prot_i;
  logic [XLEN-1:0] im_d_i;
  logic [TW-1:0] im_tagi_i;
  logic im_stb_ack_o, im_d_ack_o, im_ack_o, im_err_o;
  logic [PLEN-1:0] im_adro_o;
  logic [XLEN-1:0] im_q_o;
  logic [TW-1:0] im_tago_o;

  logic dm_stb_i, dm_we_i, dm_lock_i;
  logic [PLEN-1:0] dm_adri_i;
  biu_size_t dm_size_i;
  biu_type_t dm_type_i;
  biu_prot_t dm_prot_i;
  logic [XLEN-1:0] dm_d_i;
  logic [TW-1:0] dm_tagi_i;
  logic dm_stb_ack_o, dm_d_ack_o, dm_ack_o, dm_err_o;
  logic [PLEN-1:0] dm_adro_o;
  logic [XLEN-1:0] dm_q_o;
  logic [TW-1:0] dm_tago_o;

  biu_arb_state_t state_o;

  riscv_biu_arb_if #(.XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(TW)) biu ();

  riscv_biu_arb #(.XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .im_stb_i(im_stb_i), .im_stb_ack_o(im_stb_ack_o), .im_d_ack_o(im_d_ack_o),
    .im_ack_o(im_ack_o), .im_err_o(im_err_o), .im_adri_i(im_adri_i), .im_adro_o(im_adro_o),
    .im_size_i(im_size_i), .im_type_i(im_type_i), .im_prot_i(im_prot_i), .im_we_i(im_we_i),
    .im_lock_i(im_lock_i), .im_d_i(im_d_i), .im_q_o(im_q_o), .im_tagi_i(im_tagi_i),
    .im_tago_o(im_tago_o),
    .dm_stb_i(dm_stb_i), .dm_stb_ack_o(dm_stb_ack_o), .dm_d_ack_o(dm_d_ack_o),
    .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o), .dm_adri_i(dm_adri_i), .dm_adro_o(dm_adro_o),
    .dm_size_i(dm_size_i), .dm_type_i(dm_type_i), .dm_prot_i(dm_prot_i), .dm_we_i(dm_we_i),
    .dm_lock_i(dm_lock_i), .dm_d_i(dm_d_i), .dm_q_o(dm_q_o), .dm_tagi_i(dm_tagi_i),
    .dm_tago_o(dm_tago_o),
    .biu_stb_o(biu.stb), .biu_adri_o(biu.adri), .biu_size_o(biu.size), .biu_type_o(biu.typ),
    .biu_we_o(biu.we), .biu_lock_o(biu.lock), .biu_prot_o(biu.prot), .biu_d_o(biu.d),
    .biu_tagi_o(biu.tagi), .biu_stb_ack_i(biu.stb_ack), .biu_d_ack_i(biu.d_ack),
    .biu_ack_i(biu.ack), .biu_err_i(biu.err), .biu_adro_i(biu.adro), .biu_q_i(biu.q),
    .biu_tago_i(biu.tago),
    .state_o(state_o)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard entry: {dm_stb_ack, im_stb_ack, granted address}
  logic [PLEN+1:0] exp_q[$];
  logic [PLEN+1:0] mon_exp, mon_got;

  always @(negedge clk) begin
    if (rst_n && biu.stb && biu.stb_ack) begin
      mon_got = {dm_stb_ack_o, im_stb_ack_o, biu.adri};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL grant_order got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    im_stb_i = 0; im_we_i = 0; im_lock_i = 0; im_adri_i = '0; im_size_i = WORD;
    im_type_i = SINGLE; im_prot_i = PROT_PRIVILEGED; im_d_i = '0; im_tagi_i = '0;
    dm_stb_i = 0; dm_we_i = 0; dm_lock_i = 0; dm_adri_i = '0; dm_size_i = WORD;
    dm_type_i = SINGLE; dm_prot_i = PROT_DATA; dm_d_i = '0; dm_tagi_i = '0;
    biu.stb_ack = 0; biu.d_ack = 0; biu.ack = 0; biu.err = 0;
    biu.adro = '0; biu.q = '0; biu.tago = '0;
  endtask

  task automatic push_exp(input bit d, input logic [PLEN-1:0] a);
    exp_q.push_back({d, ~d, a});
  endtask

  task automatic apply_reset();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  // BIU responder: accepts the pending strobe, then returns 'beats' beats,
  // with biu_err_i on beat err_beat and the other side strobing from raise_beat.
  task automatic xfer(input bit d, input int beats, input int err_beat, input int raise_beat,
                      output int own_acks, output int other_hits, output int errs,
                      output int idle_beat);
    int n;
    own_acks = 0; other_hits = 0; errs = 0; idle_beat = 0; n = 0;
    #1;
    while (!biu.stb && n < 50) begin
      step();
      n++;
    end
    if (!biu.stb) begin
      idle_beat = -1;
      return;
    end
    biu.stb_ack = 1;
    step();
    biu.stb_ack = 0;
    if (d) dm_stb_i = 0; else im_stb_i = 0;
    for (int b = 1; b <= beats; b++) begin
      if (b == raise_beat) begin
        if (d) im_stb_i = 1; else dm_stb_i = 1;
      end
      if (b == err_beat) biu.err = 1; else biu.ack = 1;
      biu.q = $urandom;
      #1;
      if (d) begin
        own_acks   += int'(dm_ack_o);
        errs       += int'(dm_err_o);
        other_hits += int'(im_ack_o | im_err_o | im_stb_ack_o | im_d_ack_o);
      end else begin
        own_acks   += int'(im_ack_o);
        errs       += int'(im_err_o);
        other_hits += int'(dm_ack_o | dm_err_o | dm_stb_ack_o | dm_d_ack_o);
      end
      step();
      biu.ack = 0;
      biu.err = 0;
      if (state_o == IDLE && idle_beat == 0) idle_beat = b;
      if (b == err_beat) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    im_stb_i = 1; dm_stb_i = 1;
    biu.stb_ack = 1; biu.ack = 1; biu.err = 1; biu.d_ack = 1;
    step(); step();
    checks++;
    if (state_o !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d required=%0d", state_o, IDLE);
    end
    checks++;
    if ({biu.stb, im_stb_ack_o, im_d_ack_o, im_ack_o, im_err_o,
         dm_stb_ack_o, dm_d_ack_o, dm_ack_o, dm_err_o} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0",
               {biu.stb, im_stb_ack_o, im_d_ack_o, im_ack_o, im_err_o,
                dm_stb_ack_o, dm_d_ack_o, dm_ack_o, dm_err_o});
    end
    idle_inputs();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_instr_single();
    logic [XLEN-1:0] qv;
    qv = 32'hA5A5_0001;
    im_adri_i = 34'h100; im_type_i = SINGLE; im_stb_i = 1;
    push_exp(0, 34'h100);
    #1;
    checks++;
    if ({biu.stb, biu.adri} !== {1'b1, 34'h100}) begin
      failures++; $display("FAIL instr_request got=%b/%h required=1/100", biu.stb, biu.adri);
    end
    biu.stb_ack = 1;
    #1;
    checks++;
    if ({im_stb_ack_o, dm_stb_ack_o} !== 2'b10) begin
      failures++; $display("FAIL instr_stb_ack got=%b required=10", {im_stb_ack_o, dm_stb_ack_o});
    end
    step();
    biu.stb_ack = 0; im_stb_i = 0;
    checks++;
    if (state_o !== BUSY_I) begin
      failures++; $display("FAIL instr_busy got=%0d required=%0d", state_o, BUSY_I);
    end
    biu.ack = 1; biu.q = qv; biu.adro = 34'h100;
    #1;
    checks++;
    if ({im_ack_o, dm_ack_o, dm_err_o, dm_stb_ack_o, dm_d_ack_o, dm_adro_o} !== {5'b10000, 34'h0}) begin
      failures++; $display("FAIL instr_ack_route got=%b dm_adro=%h required=10000/0",
                           {im_ack_o, dm_ack_o, dm_err_o, dm_stb_ack_o, dm_d_ack_o}, dm_adro_o);
    end
    checks++;
    if ({im_q_o, dm_q_o, im_adro_o} !== {qv, qv, 34'h100}) begin
      failures++; $display("FAIL instr_data got=%h/%h/%h required=%h/%h/100", im_q_o, dm_q_o, im_adro_o, qv, qv);
    end
    step();
    biu.ack = 0; biu.adro = '0;
    checks++;
    if (state_o !== IDLE) begin
      failures++; $display("FAIL instr_done got=%0d required=%0d", state_o, IDLE);
    end
  endtask

  task automatic test_round_robin();
    int own, other, errs, idle;
    bit win_d;
    apply_reset();
    im_type_i = SINGLE; dm_type_i = SINGLE;
    for (int i = 0; i < 4; i++) begin
      im_adri_i = 34'h200 + 34'(i * 4);
      dm_adri_i = 34'h3000 + 34'(i * 4);
      im_stb_i = 1; dm_stb_i = 1;
      win_d = (i % 2) == 1;
      push_exp(win_d, win_d ? dm_adri_i : im_adri_i);
      xfer(win_d, 1, 0, 0, own, other, errs, idle);
      checks++;
      if ({own, other, idle} !== {32'd1, 32'd0, 32'd1}) begin
        failures++; $display("FAIL rr_tie%0d own=%0d other=%0d idle=%0d required=1/0/1", i, own, other, idle);
      end
    end
    im_stb_i = 0; dm_stb_i = 0;
    step();
  endtask

  task automatic test_data_incr4();
    int own, other, errs, idle;
    dm_adri_i = 34'h4000; dm_type_i = INCR4; dm_stb_i = 1;
    im_adri_i = 34'h500; im_type_i = SINGLE; im_stb_i = 0;
    push_exp(1, 34'h4000);
    xfer(1, 4, 0, 2, own, other, errs, idle);
    checks++;
    if ({own, other, idle} !== {32'd4, 32'd0, 32'd4}) begin
      failures++; $display("FAIL incr4_burst own=%0d other=%0d idle=%0d required=4/0/4", own, other, idle);
    end
    #1;
    checks++;
    if ({state_o == IDLE, biu.stb, biu.adri} !== {1'b1, 1'b1, 34'h500}) begin
      failures++; $display("FAIL incr4_next_grant got=%0d/%b/%h required=IDLE/1/500", state_o, biu.stb, biu.adri);
    end
    push_exp(0, 34'h500);
    xfer(0, 1, 0, 0, own, other, errs, idle);
    checks++;
    if ({own, idle} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL incr4_followup own=%0d idle=%0d required=1/1", own, idle);
    end
  endtask

  task automatic test_err();
    int own, other, errs, idle;
    dm_adri_i = 34'h6000; dm_type_i = WRAP8; dm_stb_i = 1;
    push_exp(1, 34'h6000);
    xfer(1, 8, 3, 0, own, other, errs, idle);
    checks++;
    if ({own, errs, other, idle} !== {32'd2, 32'd1, 32'd0, 32'd3}) begin
      failures++; $display("FAIL wrap8_err own=%0d err=%0d other=%0d idle=%0d required=2/1/0/3", own, errs, other, idle);
    end
    biu.ack = 1;
    #1;
    checks++;
    if ({dm_err_o, dm_ack_o, state_o == IDLE} !== 3'b001) begin
      failures++; $display("FAIL wrap8_after_err got=%b required=001", {dm_err_o, dm_ack_o, state_o == IDLE});
    end
    step();
    biu.ack = 0;
  endtask

  task automatic test_lock();
    int own, other, errs, idle;
    dm_adri_i = 34'h7000; dm_type_i = SINGLE; dm_lock_i = 1; dm_stb_i = 1;
    im_stb_i = 0;
    push_exp(1, 34'h7000);
    xfer(1, 1, 0, 0, own, other, errs, idle);
    checks++;
    if ({own, idle} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL lock_first own=%0d idle=%0d required=1/1", own, idle);
    end
    im_adri_i = 34'h800; im_type_i = SINGLE; im_stb_i = 1;
    #1;
    checks++;
    if ({biu.stb, state_o == IDLE} !== 2'b01) begin
      failures++; $display("FAIL lock_blocks_instr got=%b required=01", {biu.stb, state_o == IDLE});
    end
    step();
    dm_adri_i = 34'h7004; dm_stb_i = 1;
    push_exp(1, 34'h7004);
    xfer(1, 1, 0, 0, own, other, errs, idle);
    checks++;
    if ({own, other, idle} !== {32'd1, 32'd0, 32'd1}) begin
      failures++; $display("FAIL lock_second own=%0d other=%0d idle=%0d required=1/0/1", own, other, idle);
    end
    dm_lock_i = 0;
    push_exp(0, 34'h800);
    xfer(0, 1, 0, 0, own, other, errs, idle);
    checks++;
    if ({own, idle} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL lock_release own=%0d idle=%0d required=1/1", own, idle);
    end
  endtask

  task automatic test_reset_mid_burst();
    dm_adri_i = 34'h9000; dm_type_i = INCR4; dm_stb_i = 1;
    push_exp(1, 34'h9000);
    #1;
    biu.stb_ack = 1;
    step();
    biu.stb_ack = 0; dm_stb_i = 0;
    biu.ack = 1;
    step();
    rst_n = 0;
    #1;
    checks++;
    if ({state_o == IDLE, biu.stb, dm_ack_o, im_ack_o} !== 4'b1000) begin
      failures++; $display("FAIL midburst_reset got=%b required=1000", {state_o == IDLE, biu.stb, dm_ack_o, im_ack_o});
    end
    step();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      biu.err = (c == 1);
      step();
      checks++;
      if ({state_o == IDLE, dm_ack_o, dm_err_o, im_ack_o, im_err_o} !== 5'b10000) begin
        failures++; $display("FAIL post_reset_ack%0d got=%b required=10000",
                             c, {state_o == IDLE, dm_ack_o, dm_err_o, im_ack_o, im_err_o});
      end
    end
    biu.ack = 0; biu.err = 0;
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_instr_single();
    test_round_robin();
    test_data_incr4();
    test_err();
    test_lock();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_biu_arb.md
RISCV_BIU_ARB -- requirements
Module: riscv_biu_arb

Interface
REQ-001 Parameter XLEN, default 32: data width.
REQ-002 Parameter PLEN, default XLEN==32 ? 34 : 56: physical address width.
REQ-003 Parameter BIUTAG_SIZE, default 1: transfer tag width.
REQ-004 Ports: clk_i in 1, the single clock.
REQ-005 Ports: rst_ni in 1, asynchronous active-low reset.
REQ-006 im_/dm_ stb_i in 1 each: request strobe from the instruction and data memory controllers.
REQ-007 im_/dm_ stb_ack_o, d_ack_o, ack_o, err_o out 1 each: gated BIU responses to each requester.
REQ-008 im_/dm_ adri_i in PLEN, adro_o out PLEN: request address and returned address.
REQ-009 im_/dm_ size_i, type_i, prot_i in biu_size_t/biu_type_t/biu_prot_t: transfer attributes.
REQ-010 im_/dm_ we_i, lock_i in 1; d_i in XLEN; q_o out XLEN; tagi_i in BIUTAG_SIZE; tago_o out BIUTAG_SIZE.
REQ-011 biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_we_o, biu_lock_o, biu_prot_o, biu_d_o, biu_tagi_o out: shared BIU request.
REQ-012 biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i in 1; biu_adro_i in PLEN; biu_q_i in XLEN; biu_tago_i in BIUTAG_SIZE: shared BIU response.

Function
REQ-013 States: IDLE, BUSY_I, BUSY_D.
REQ-014 In IDLE, grant is combinational: only one strobe -> that requester; both -> the requester not served last (round-robin flag rr_last).
REQ-015 Locked owner: if the last owner's lock_i is still high in IDLE, that owner alone is granted and the other strobe is ignored.
REQ-016 Granted requester's attributes drive biu_*; biu_stb_o = granted stb in IDLE only, 0 in BUSY states.
REQ-017 biu_stb_ack_i in IDLE -> BUSY_x next cycle; beat counter loaded with beats(type): SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
REQ-018 In BUSY_x, each biu_ack_i decrements the counter; at counter==1 with ack -> IDLE next cycle.
REQ-019 biu_err_i in BUSY_x terminates the burst: -> IDLE next cycle regardless of count.
REQ-020 stb_ack, d_ack, ack, err, adro, tago go only to the owner (IDLE: granted; BUSY: owner); the non-owner sees 0. q_o = biu_q_i to both.
REQ-021 rr_last updates to the granted requester on biu_stb_ack_i.
REQ-022 stb and ack in the same cycle are not possible in IDLE; a BIU ack in IDLE is ignored.
REQ-023 A requester dropping stb_i in BUSY does not abort the burst.

Reset
REQ-024 On rst_ni low, asynchronously: state IDLE, counter 0, rr_last = data (so instruction wins the first tie), lock owner cleared.
REQ-025 Outputs during reset: biu_stb_o 0, all *_ack_o/err_o 0.
REQ-026 Reset mid-burst discards the burst; no response is forwarded after release until a new stb_ack.

Structure
REQ-027 Burst-length decode function and the state enum belong in biu_constants_pkg.
REQ-028 Single module with no sub-module; requester selection uses one 2:1 mux per field.

Verification
REQ-029 Instruction-only SINGLE at 0x100: stb_ack -> BUSY_I, one ack -> IDLE; dm_* responses stay 0 throughout.
REQ-030 Simultaneous stb after reset -> instruction granted; next tie -> data granted; alternation holds over 4 ties.
REQ-031 Data INCR4: four acks, and IDLE is reached only on the 4th; an instruction stb raised mid-burst is granted in the IDLE cycle after.
REQ-032 Data WRAP8 with biu_err_i on the 3rd beat -> dm_err_o 1 for one cycle, IDLE next cycle.
REQ-033 Data lock_i held across two SINGLEs with instruction strobing -> both data transfers complete before the instruction grant.
REQ-034 rst_ni low during beat 2 of INCR4 -> IDLE immediately; later BIU acks are not forwarded.
